// File: rtl/sram_bist_pkg.sv
// Shared types for the SRAM march-test engine: FSM state encoding, the march
// element operation descriptor and the read-latency ceiling.
// Optional feature macro used by this slice: SRAM_BIST_FAIL_ADDR_EN.
package sram_bist_pkg;

  localparam int unsigned READ_LATENCY_MAX = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_M0,
    ST_M1,
    ST_M2,
    ST_M3,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // One bus operation of a march element.
  // dir: 0 = ascending, 1 = descending; data_inv selects ~P instead of P.
  typedef struct packed {
    logic dir;
    logic read;
    logic write;
    logic data_inv;
  } march_op_t;

  // Operation issued in the current cycle. Two-op elements (M1, M2) read in
  // phase 0 and write in phase 1 of the same address.
  function automatic march_op_t march_op(state_e st, logic phase);
    march_op_t op;
    op = '0;
    case (st)
      ST_M0:   op = '{dir: 1'b0, read: 1'b0, write: 1'b1, data_inv: 1'b0};
      ST_M1:   op = phase ? '{dir: 1'b0, read: 1'b0, write: 1'b1, data_inv: 1'b1}
                          : '{dir: 1'b0, read: 1'b1, write: 1'b0, data_inv: 1'b0};
      ST_M2:   op = phase ? '{dir: 1'b1, read: 1'b0, write: 1'b1, data_inv: 1'b0}
                          : '{dir: 1'b1, read: 1'b1, write: 1'b0, data_inv: 1'b1};
      ST_M3:   op = '{dir: 1'b0, read: 1'b1, write: 1'b0, data_inv: 1'b0};
      default: op = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// Per-channel read-data comparator with a sticky mismatch flag.
// With SRAM_BIST_FAIL_ADDR_EN defined, the raw per-cycle mismatch is also
// exported so the top level can capture the first failing address.
module sram_bist_cmp
  import sram_bist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear_i,
  input  logic                  check_i,
  input  logic [DATA_WIDTH-1:0] expected_i,
  input  logic [DATA_WIDTH-1:0] dout_i,
`ifdef SRAM_BIST_FAIL_ADDR_EN
  output logic                  mismatch_o,
`endif
  output logic                  fail_o
);

  logic mismatch;
  logic fail_q, fail_d;

  // Compare only when the read pipe presents a valid word for this channel.
  always_comb begin
    mismatch = check_i && (dout_i != expected_i);
    fail_d   = fail_q;
    if (clear_i) begin
      fail_d = 1'b0;
    end else if (mismatch) begin
      fail_d = 1'b1;
    end
  end

  // Sticky fail flag, cleared only by an accepted start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fail_q <= 1'b0;
    end else begin
      fail_q <= fail_d;
    end
  end

  assign fail_o = fail_q;
`ifdef SRAM_BIST_FAIL_ADDR_EN
  assign mismatch_o = mismatch;
`endif

endmodule

// File: rtl/sram_bist_ctrl.sv
// March-test BIST engine for NUM_SRAMS macros sharing one address/data bus.
// Runs M0 w(P) up, M1 r(P)w(~P) up, M2 r(~P)w(P) down, M3 r(P) up, then
// drains the read-compare pipe. Optional first-fail address capture is
// enabled by defining SRAM_BIST_FAIL_ADDR_EN.
module sram_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int unsigned NUM_SRAMS    = 12,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            start,
  input  logic [NUM_SRAMS-1:0]            chan_en,
  input  logic [DATA_WIDTH-1:0]           pattern,
  output logic [NUM_SRAMS-1:0]            sram_csb,
  output logic                            sram_web,
  output logic [ADDR_WIDTH-1:0]           sram_addr,
  output logic [DATA_WIDTH-1:0]           sram_din,
  input  logic [NUM_SRAMS*DATA_WIDTH-1:0] sram_dout,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_SRAMS-1:0]            fail,
  output logic [ADDR_WIDTH-1:0]           fail_addr,
  output logic                            fail_valid
);

  localparam int unsigned RL = (READ_LATENCY < 1) ? 1 :
                               (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX :
                               READ_LATENCY;
  localparam logic [1:0] DRAIN_LAST = 2'(RL);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    phase_q, phase_d;
  logic [1:0]              drain_q, drain_d;
  logic [NUM_SRAMS-1:0]    chan_q, chan_d;
  logic [DATA_WIDTH-1:0]   pat_q, pat_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  march_op_t               op;
  logic                    in_march;
  logic                    accept;
  logic                    addr_last;
  logic [ADDR_WIDTH-1:0]   addr_step;
  logic [DATA_WIDTH-1:0]   op_data;

  logic [RL-1:0]           pv_q;
  logic [DATA_WIDTH-1:0]   pe_q [RL];

  // Decode the current march operation and the address walk it implies.
  always_comb begin
    op        = march_op(state_q, phase_q);
    in_march  = (state_q == ST_M0) || (state_q == ST_M1) ||
                (state_q == ST_M2) || (state_q == ST_M3);
    op_data   = op.data_inv ? ~pat_q : pat_q;
    addr_step = op.dir ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
    addr_last = op.dir ? (addr_q == '0) : (addr_q == '1);
    accept    = start && !busy_q && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  end

  // busy/done are registered flags rather than state decodes: done rises one
  // cycle after DONE is entered, which also yields the one-cycle busy pulse
  // when no channel is enabled.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    drain_d = drain_q;
    chan_d  = chan_q;
    pat_d   = pat_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (busy_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (accept) begin
          chan_d  = chan_en;
          pat_d   = pattern;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          addr_d  = '0;
          phase_d = 1'b0;
          state_d = (chan_en == '0) ? ST_DONE : ST_M0;
        end
      end
      ST_M0: begin
        addr_d = addr_step;
        if (addr_last) begin
          state_d = ST_M1;
          addr_d  = '0;
        end
      end
      ST_M1: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          addr_d = addr_step;
          if (addr_last) begin
            state_d = ST_M2;
            addr_d  = '1;
          end
        end
      end
      ST_M2: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          addr_d = addr_step;
          if (addr_last) begin
            state_d = ST_M3;
            addr_d  = '0;
          end
        end
      end
      ST_M3: begin
        addr_d = addr_step;
        if (addr_last) begin
          state_d = ST_DRAIN;
          addr_d  = '0;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      phase_q <= 1'b0;
      drain_q <= '0;
      chan_q  <= '0;
      pat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      drain_q <= drain_d;
      chan_q  <= chan_d;
      pat_q   <= pat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Drive the shared SRAM bus; idle whenever no march element is active.
  always_comb begin
    sram_csb = '1;
    sram_web = 1'b1;
    sram_din = '0;
    if (in_march) begin
      sram_csb = ~chan_q;
      if (op.write) begin
        sram_web = 1'b0;
        sram_din = op_data;
      end
    end
  end

  assign sram_addr = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Read pipe: each issued read carries its expected word until dout is valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pv_q <= '0;
      for (int unsigned j = 0; j < RL; j++) begin
        pe_q[j] <= '0;
      end
    end else begin
      pv_q[0] <= in_march && op.read;
      pe_q[0] <= op_data;
      for (int unsigned j = 1; j < RL; j++) begin
        pv_q[j] <= pv_q[j-1];
        pe_q[j] <= pe_q[j-1];
      end
    end
  end

`ifdef SRAM_BIST_FAIL_ADDR_EN
  logic [NUM_SRAMS-1:0]  mismatch;
  logic [ADDR_WIDTH-1:0] pa_q [RL];
  logic [ADDR_WIDTH-1:0] fa_q, fa_d;
  logic                  fv_q, fv_d;

  // Carry the read address alongside the expected word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned j = 0; j < RL; j++) begin
        pa_q[j] <= '0;
      end
    end else begin
      pa_q[0] <= addr_q;
      for (int unsigned j = 1; j < RL; j++) begin
        pa_q[j] <= pa_q[j-1];
      end
    end
  end

  // First mismatch of a run wins; later ones never overwrite it.
  always_comb begin
    fa_d = fa_q;
    fv_d = fv_q;
    if (accept) begin
      fa_d = '0;
      fv_d = 1'b0;
    end else if ((mismatch != '0) && !fv_q) begin
      fa_d = pa_q[RL-1];
      fv_d = 1'b1;
    end
  end

  // First-fail capture registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fa_q <= '0;
      fv_q <= 1'b0;
    end else begin
      fa_q <= fa_d;
      fv_q <= fv_d;
    end
  end

  assign fail_addr  = fa_q;
  assign fail_valid = fv_q;
`else
  assign fail_addr  = '0;
  assign fail_valid = 1'b0;
`endif

  for (genvar i = 0; i < NUM_SRAMS; i++) begin : g_cmp
    sram_bist_cmp #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_cmp (
      .clk       (clk),
      .resetn    (resetn),
      .clear_i   (accept),
      .check_i   (pv_q[RL-1] && chan_q[i]),
      .expected_i(pe_q[RL-1]),
      .dout_i    (sram_dout[i*DATA_WIDTH +: DATA_WIDTH]),
`ifdef SRAM_BIST_FAIL_ADDR_EN
      .mismatch_o(mismatch[i]),
`endif
      .fail_o    (fail[i])
    );
  end

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Directed bench for sram_bist_ctrl: two engines (read latency 1 and 3), each
// attached to its own behavioural SRAM array with an optional stuck-at-1 on
// bit 3 of channel 2, address 5.
module tb_sram_bist_ctrl;

  localparam int NS = 4;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int D  = 16;

`ifdef SRAM_BIST_FAIL_ADDR_EN
  localparam logic [AW-1:0] EXP_FA = 4'd5;
  localparam logic          EXP_FV = 1'b1;
`else
  localparam logic [AW-1:0] EXP_FA = 4'd0;
  localparam logic          EXP_FV = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn, start0, start1, fault_en;
  logic [NS-1:0] chan_en;
  logic [DW-1:0] pattern;

  logic [NS-1:0]    csb [2];
  logic             web [2];
  logic [AW-1:0]    addr [2];
  logic [DW-1:0]    din [2];
  logic [NS*DW-1:0] dout [2];
  logic             busy [2];
  logic             done [2];
  logic [NS-1:0]    fail [2];
  logic [AW-1:0]    fail_addr [2];
  logic             fail_valid [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic mon_en = 1'b0;
  logic csb2_seen, csb_any_seen;

  always #5 clk = ~clk;

  sram_bist_ctrl #(
    .NUM_SRAMS(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)
  ) u0 (
    .clk(clk), .resetn(resetn), .start(start0), .chan_en(chan_en), .pattern(pattern),
    .sram_csb(csb[0]), .sram_web(web[0]), .sram_addr(addr[0]), .sram_din(din[0]),
    .sram_dout(dout[0]), .busy(busy[0]), .done(done[0]), .fail(fail[0]),
    .fail_addr(fail_addr[0]), .fail_valid(fail_valid[0])
  );

  sram_bist_ctrl #(
    .NUM_SRAMS(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)
  ) u1 (
    .clk(clk), .resetn(resetn), .start(start1), .chan_en(chan_en), .pattern(pattern),
    .sram_csb(csb[1]), .sram_web(web[1]), .sram_addr(addr[1]), .sram_din(din[1]),
    .sram_dout(dout[1]), .busy(busy[1]), .done(done[1]), .fail(fail[1]),
    .fail_addr(fail_addr[1]), .fail_valid(fail_valid[1])
  );

  // Behavioural SRAMs: write on !csb & !web, read data appears RL cycles later.
  for (genvar m = 0; m < 2; m++) begin : g_mem
    localparam int RLM = (m == 0) ? 1 : 3;
    logic [DW-1:0]    mem [NS][D];
    logic [DW-1:0]    rdp [NS][3];
    logic [NS*DW-1:0] dm;

    always @(posedge clk) begin
      for (int c = 0; c < NS; c++) begin
        for (int j = 1; j < 3; j++) rdp[c][j] <= rdp[c][j-1];
        if (csb[m][c] == 1'b0) begin
          if (web[m] == 1'b0)
            mem[c][addr[m]] <= (fault_en && c == 2 && addr[m] == 4'd5) ? (din[m] | 32'h8) : din[m];
          else
            rdp[c][0] <= mem[c][addr[m]];
        end
      end
    end

    always_comb begin
      dm = '0;
      for (int c = 0; c < NS; c++) dm[c*DW +: DW] = rdp[c][RLM-1];
    end

    assign dout[m] = dm;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (csb[0][2] == 1'b0) csb2_seen = 1'b1;
      if (csb[0] != 4'hF) csb_any_seen = 1'b1;
    end
  end

  task automatic pulse_start(input int m);
    @(posedge clk); #1;
    if (m == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Called right after pulse_start; returns the edge index (start edge = 0)
  // at which done is first seen high, or -1 if it never rises.
  task automatic wait_done(input int m, output int cyc);
    cyc = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (done[m] === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int cyc;
    resetn = 1'b0; start0 = 1'b0; start1 = 1'b0; fault_en = 1'b0;
    chan_en = '0; pattern = '0;
    #23;
    n_cmp++; if (csb[0] !== 4'hF) begin n_bad++; $display("FAIL reset_csb: got %h want f", csb[0]); end
    n_cmp++; if (web[0] !== 1'b1) begin n_bad++; $display("FAIL reset_web: got %b want 1", web[0]); end
    n_cmp++; if (addr[0] !== 4'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", addr[0]); end
    n_cmp++; if (din[0] !== 32'd0) begin n_bad++; $display("FAIL reset_din: got %h want 0", din[0]); end
    n_cmp++; if ({busy[0], done[0]} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done: got %b want 00", {busy[0], done[0]}); end
    n_cmp++; if (fail[0] !== 4'h0) begin n_bad++; $display("FAIL reset_fail: got %h want 0", fail[0]); end
    n_cmp++; if ({fail_valid[0], fail_addr[0]} !== 5'd0) begin n_bad++; $display("FAIL reset_fail_addr: got %h want 0", {fail_valid[0], fail_addr[0]}); end
    @(negedge clk); resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cyc = 0;
    n_cmp++; if ({busy[0], done[0], csb[0]} !== 6'b00_1111) begin n_bad++; $display("FAIL idle_after_reset: got %b want 001111", {busy[0], done[0], csb[0]}); end
  endtask

  task automatic test_good_run;
    int cyc;
    chan_en = 4'hF; pattern = 32'hA5A5A5A5; fault_en = 1'b0;
    pulse_start(0);
    n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL good_busy_c0: got %b want 1", busy[0]); end
    n_cmp++; if ({csb[0], web[0], addr[0]} !== {4'h0, 1'b0, 4'd0}) begin n_bad++; $display("FAIL good_bus_c0: got %h want 000", {csb[0], web[0], addr[0]}); end
    n_cmp++; if (din[0] !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL good_din_c0: got %h want a5a5a5a5", din[0]); end
    wait_done(0, cyc);
    n_cmp++; if (cyc !== 99) begin n_bad++; $display("FAIL good_done_cycle: got %0d want 99", cyc); end
    n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL good_busy_end: got %b want 0", busy[0]); end
    n_cmp++; if (fail[0] !== 4'h0) begin n_bad++; $display("FAIL good_fail: got %h want 0", fail[0]); end
    n_cmp++; if (fail_valid[0] !== 1'b0) begin n_bad++; $display("FAIL good_fail_valid: got %b want 0", fail_valid[0]); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({done[0], csb[0]} !== 5'b1_1111) begin n_bad++; $display("FAIL good_done_held: got %b want 11111", {done[0], csb[0]}); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    pulse_start(0);
    n_cmp++; if ({busy[0], done[0]} !== 2'b10) begin n_bad++; $display("FAIL b2b_restart: got %b want 10", {busy[0], done[0]}); end
    wait_done(0, cyc);
    n_cmp++; if (cyc !== 99) begin n_bad++; $display("FAIL b2b_done_cycle: got %0d want 99", cyc); end
  endtask

  task automatic test_stuck_fault;
    int cyc;
    chan_en = 4'hF; pattern = 32'hA5A5A5A5; fault_en = 1'b1;
    pulse_start(0);
    wait_done(0, cyc);
    n_cmp++; if (cyc !== 99) begin n_bad++; $display("FAIL fault_done_cycle: got %0d want 99", cyc); end
    n_cmp++; if (fail[0] !== 4'b0100) begin n_bad++; $display("FAIL fault_fail: got %b want 0100", fail[0]); end
    n_cmp++; if (fail_addr[0] !== EXP_FA) begin n_bad++; $display("FAIL fault_addr: got %0d want %0d", fail_addr[0], EXP_FA); end
    n_cmp++; if (fail_valid[0] !== EXP_FV) begin n_bad++; $display("FAIL fault_valid: got %b want %b", fail_valid[0], EXP_FV); end
  endtask

  task automatic test_chan_mask;
    int cyc;
    chan_en = 4'b1011; pattern = 32'hA5A5A5A5; fault_en = 1'b1;
    csb2_seen = 1'b0; mon_en = 1'b1;
    pulse_start(0);
    n_cmp++; if (csb[0] !== 4'b0100) begin n_bad++; $display("FAIL mask_csb_c0: got %b want 0100", csb[0]); end
    wait_done(0, cyc);
    mon_en = 1'b0;
    n_cmp++; if (cyc !== 99) begin n_bad++; $display("FAIL mask_done_cycle: got %0d want 99", cyc); end
    n_cmp++; if (fail[0] !== 4'h0) begin n_bad++; $display("FAIL mask_fail: got %b want 0000", fail[0]); end
    n_cmp++; if (fail_valid[0] !== 1'b0) begin n_bad++; $display("FAIL mask_fail_valid: got %b want 0", fail_valid[0]); end
    n_cmp++; if (csb2_seen !== 1'b0) begin n_bad++; $display("FAIL mask_csb2_active: got %b want 0", csb2_seen); end
  endtask

  task automatic test_chan_zero;
    chan_en = 4'h0; fault_en = 1'b1;
    csb_any_seen = 1'b0; mon_en = 1'b1;
    pulse_start(0);
    n_cmp++; if ({busy[0], done[0]} !== 2'b10) begin n_bad++; $display("FAIL zero_c0: got %b want 10", {busy[0], done[0]}); end
    @(posedge clk); #1;
    n_cmp++; if ({busy[0], done[0]} !== 2'b01) begin n_bad++; $display("FAIL zero_c1: got %b want 01", {busy[0], done[0]}); end
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    n_cmp++; if (fail[0] !== 4'h0) begin n_bad++; $display("FAIL zero_fail: got %b want 0000", fail[0]); end
    n_cmp++; if (csb_any_seen !== 1'b0) begin n_bad++; $display("FAIL zero_csb_active: got %b want 0", csb_any_seen); end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    chan_en = 4'hF; pattern = 32'hA5A5A5A5; fault_en = 1'b1;
    pulse_start(0);
    repeat (59) @(posedge clk);
    #1;
    n_cmp++; if (fail[0] !== 4'b0100) begin n_bad++; $display("FAIL mid_fail_before_rst: got %b want 0100", fail[0]); end
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if ({busy[0], done[0]} !== 2'b00) begin n_bad++; $display("FAIL mid_rst_busy_done: got %b want 00", {busy[0], done[0]}); end
    n_cmp++; if ({csb[0], web[0], addr[0]} !== {4'hF, 1'b1, 4'd0}) begin n_bad++; $display("FAIL mid_rst_bus: got %h want 1f0", {csb[0], web[0], addr[0]}); end
    n_cmp++; if (din[0] !== 32'd0) begin n_bad++; $display("FAIL mid_rst_din: got %h want 0", din[0]); end
    n_cmp++; if (fail[0] !== 4'h0) begin n_bad++; $display("FAIL mid_rst_fail: got %b want 0000", fail[0]); end
    n_cmp++; if ({fail_valid[0], fail_addr[0]} !== 5'd0) begin n_bad++; $display("FAIL mid_rst_fail_addr: got %h want 0", {fail_valid[0], fail_addr[0]}); end
    @(negedge clk); resetn = 1'b1; fault_en = 1'b0;
    pulse_start(0);
    wait_done(0, cyc);
    n_cmp++; if (cyc !== 99) begin n_bad++; $display("FAIL mid_rerun_done_cycle: got %0d want 99", cyc); end
    n_cmp++; if (fail[0] !== 4'h0) begin n_bad++; $display("FAIL mid_rerun_fail: got %b want 0000", fail[0]); end
  endtask

  task automatic test_start_while_busy;
    int cyc;
    chan_en = 4'hF; pattern = 32'h3C3C_0FF0; fault_en = 1'b0;
    pulse_start(0);
    cyc = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (k == 39) start0 = 1'b1;
      if (k == 40) start0 = 1'b0;
      if (done[0] === 1'b1) begin
        cyc = k;
        break;
      end
    end
    n_cmp++; if (cyc !== 99) begin n_bad++; $display("FAIL busy_start_done_cycle: got %0d want 99", cyc); end
    n_cmp++; if (fail[0] !== 4'h0) begin n_bad++; $display("FAIL busy_start_fail: got %b want 0000", fail[0]); end
  endtask

  task automatic test_rl3;
    int cyc;
    chan_en = 4'hF; pattern = 32'hA5A5A5A5; fault_en = 1'b0;
    pulse_start(1);
    wait_done(1, cyc);
    n_cmp++; if (cyc !== 6*D+5) begin n_bad++; $display("FAIL rl3_done_cycle: got %0d want %0d", cyc, 6*D+5); end
    n_cmp++; if ({busy[1], fail[1]} !== 5'd0) begin n_bad++; $display("FAIL rl3_clean: got %b want 00000", {busy[1], fail[1]}); end
    fault_en = 1'b1;
    pulse_start(1);
    wait_done(1, cyc);
    n_cmp++; if (cyc !== 6*D+5) begin n_bad++; $display("FAIL rl3_fault_done_cycle: got %0d want %0d", cyc, 6*D+5); end
    n_cmp++; if (fail[1] !== 4'b0100) begin n_bad++; $display("FAIL rl3_fault_fail: got %b want 0100", fail[1]); end
    n_cmp++; if ({fail_valid[1], fail_addr[1]} !== {EXP_FV, EXP_FA}) begin n_bad++; $display("FAIL rl3_fault_addr: got %h want %h", {fail_valid[1], fail_addr[1]}, {EXP_FV, EXP_FA}); end
    fault_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_good_run();
    test_back_to_back();
    test_stuck_fault();
    test_chan_mask();
    test_chan_zero();
    test_reset_mid_run();
    test_start_while_busy();
    test_rl3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
